sna_frac_multiplier: RTL and testbench

// - Sequential shift-and-add multiplier. Computes an unsigned 7-bit integer times an unsigned Q0.8 fraction.
// - Complement of the shift-and-subtract divider that produces the Q0.8 fraction. It rescales a fraction

---
 rtl/sna_frac_multiplier.sv | 95 +++++++++
 tb/tb_sna_frac_multiplier.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sna_frac_multiplier.sv
// rtl/sna_frac_multiplier.sv - sequential shift-and-add multiplier, 7-bit integer times Q0.8 fraction
// Optional macro ROUND_NEAREST_EN: int_val rounds half up instead of flooring.
module sna_frac_multiplier #(
   parameter int INT_W  = 7,
   parameter int FRAC_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [INT_W-1:0]          multiplicand,
   input  logic [FRAC_W-1:0]         frac_val,
   output logic                      busy,
   output logic                      done,
   output logic [INT_W+FRAC_W-1:0]   product,
   output logic [INT_W-1:0]          int_val
);

   localparam int P_W   = INT_W + FRAC_W;
   localparam int CNT_W = $clog2(FRAC_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [INT_W-1:0]   mcand;
   logic [FRAC_W-1:0]  frac;
   logic [P_W-1:0]     acc, acc_nxt;
   logic               accept, last;

   // MSB-first: each new fraction bit weighs half of the previous one, so shift then add.
   assign acc_nxt = (acc << 1) + (frac[cnt] ? P_W'(mcand) : P_W'(0));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         mcand   <= '0;
         frac    <= '0;
         acc     <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mcand <= multiplicand;
            frac  <= frac_val;
            acc   <= '0;
            cnt   <= CNT_W'(FRAC_W - 1);
         end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (last) product <= acc_nxt;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

`ifdef ROUND_NEAREST_EN
   // Adding half an LSB then flooring equals flooring plus the first fraction bit; max 126+1 fits.
   assign int_val = product[P_W-1:FRAC_W] + INT_W'(product[FRAC_W-1]);
`else
   assign int_val = product[P_W-1:FRAC_W];
`endif

endmodule

// File: tb/tb_sna_frac_multiplier.sv
// tb/tb_sna_frac_multiplier.sv - directed vector bench for sna_frac_multiplier
module tb_sna_frac_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  multiplicand;
   logic [7:0]  frac_val;
   logic        busy;
   logic        done;
   logic [14:0] product;
   logic [6:0]  int_val;

   int checks   = 0;
   int failures = 0;
   int prev_prod = 0;

   typedef struct {
      logic [6:0] m;
      logic [7:0] f;
      int         p;
      int         i_floor;
      int         i_round;
   } vec_t;

   vec_t vecs[8];

   sna_frac_multiplier dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .frac_val     (frac_val),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .int_val      (int_val)
   );

   always #5 clk = ~clk;

   function automatic int pick_int(input int fl, input int rn);
`ifdef ROUND_NEAREST_EN
      return rn;
`else
      return fl;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input logic [6:0] m, input logic [7:0] f, input int ep, input int ei,
                         input string nm);
      int n;
      @(negedge clk);
      multiplicand = m;
      frac_val     = f;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      multiplicand = ~m;
      frac_val     = ~f;
      chk({nm, "_busy"}, int'(busy), 1);
      chk({nm, "_held"}, int'(product), prev_prod);
      wait_done(n);
      chk({nm, "_latency"}, n, 8);
      chk({nm, "_busy_at_done"}, int'(busy), 0);
      chk({nm, "_product"}, int'(product), ep);
      chk({nm, "_int_val"}, int'(int_val), ei);
      prev_prod = ep;
      @(negedge clk);
      chk({nm, "_done_1cyc"}, int'(done), 0);
   endtask

   initial begin
      int n;
      int done_seen;

      vecs[0] = '{7'd100, 8'h80, 12800, 50,  50};
      vecs[1] = '{7'd127, 8'hFF, 32385, 126, 127};
      vecs[2] = '{7'd3,   8'h55, 255,   0,   1};
      vecs[3] = '{7'd0,   8'hAB, 0,     0,   0};
      vecs[4] = '{7'd55,  8'h00, 0,     0,   0};
      vecs[5] = '{7'd1,   8'h01, 1,     0,   0};
      vecs[6] = '{7'd127, 8'h80, 16256, 63,  64};
      vecs[7] = '{7'd10,  8'h40, 640,   2,   3};

      rst = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      frac_val = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_product", int'(product), 0);
      chk("reset_int_val", int'(int_val), 0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++)
         run_op(vecs[k].m, vecs[k].f, vecs[k].p, pick_int(vecs[k].i_floor, vecs[k].i_round),
                $sformatf("vec%0d", k));

      // start pulse at E3 while busy must be ignored
      @(negedge clk);
      multiplicand = 7'd100; frac_val = 8'h80; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      multiplicand = 7'd5; frac_val = 8'h10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("ign_latency", n, 5);
      chk("ign_product", int'(product), 12800);
      chk("ign_int_val", int'(int_val), 50);
      @(negedge clk);
      chk("ign_idle_busy", int'(busy), 0);
      chk("ign_idle_done", int'(done), 0);

      // back-to-back with start held high
      multiplicand = 7'd10; frac_val = 8'h40; start = 1'b1;
      @(negedge clk);
      multiplicand = 7'd20;
      wait_done(n);
      chk("b2b_lat1", n, 8);
      chk("b2b_prod1", int'(product), 640);
      chk("b2b_int1", int'(int_val), pick_int(2, 3));
      @(negedge clk);
      start = 1'b0; multiplicand = '0; frac_val = '0;
      chk("b2b_restart_busy", int'(busy), 1);
      chk("b2b_restart_done", int'(done), 0);
      chk("b2b_held", int'(product), 640);
      wait_done(n);
      chk("b2b_lat2", n, 8);
      chk("b2b_prod2", int'(product), 1280);
      chk("b2b_int2", int'(int_val), 5);
      @(negedge clk);
      chk("b2b_end_done", int'(done), 0);
      chk("b2b_end_busy", int'(busy), 0);

      // asynchronous reset at E4 of an operation
      multiplicand = 7'd50; frac_val = 8'hC0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_product", int'(product), 0);
      chk("arst_int_val", int'(int_val), 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      chk("arst_no_done", done_seen, 0);
      prev_prod = 0;
      run_op(7'd50, 8'hC0, 9600, pick_int(37, 38), "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
